// File: rtl/mmio_pkg.sv
// Shared types and default address map for the MMIO interconnect.
package mmio_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEF_N_SLV   = 4;
  localparam int unsigned DEF_TIMEOUT = 16;

  localparam logic [31:0] DEF_ERR_DATA = 32'hDEAD_BEEF;

  // Slot 0 (DMEM) occupies the least significant word.
  localparam logic [127:0] DEF_SLV_BASE = {32'h1004_0000, 32'h1003_0000, 32'h1002_0000, 32'h1001_0000};
  localparam logic [127:0] DEF_SLV_MASK = {4{32'hFFFF_0000}};

  // Slot index width; a single-slave map still needs one bit.
  function automatic int unsigned slot_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mmio_interconnect_if.sv
// CPU data port plus peripheral fan-out signals of the MMIO interconnect.
interface mmio_interconnect_if
  import mmio_pkg::*;
#(
  parameter int unsigned N_SLV = DEF_N_SLV
);

  logic [31:0]         cpu_addr;
  logic [31:0]         cpu_wdata;
  logic                cpu_we;
  logic                cpu_re;
  logic [31:0]         cpu_rdata;
  logic                cpu_stall;
  logic                bus_err;
  logic [31:0]         err_addr;
  logic                err_clr;
  logic [N_SLV-1:0]    slv_sel;
  logic                slv_we;
  logic [31:0]         slv_addr;
  logic [31:0]         slv_wdata;
  logic [N_SLV-1:0]    slv_ack;
  logic [N_SLV*32-1:0] slv_rdata;

  // CPU and peripherals together form the environment around the interconnect.
  modport master (
    output cpu_addr, cpu_wdata, cpu_we, cpu_re, err_clr, slv_ack, slv_rdata,
    input  cpu_rdata, cpu_stall, bus_err, err_addr, slv_sel, slv_we, slv_addr, slv_wdata
  );

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_we, cpu_re, err_clr, slv_ack, slv_rdata,
    output cpu_rdata, cpu_stall, bus_err, err_addr, slv_sel, slv_we, slv_addr, slv_wdata
  );

endinterface

// File: rtl/mmio_decode.sv
// Address window match with lowest-index priority on overlapping windows.
module mmio_decode
  import mmio_pkg::*;
#(
  parameter int unsigned         N_SLV    = DEF_N_SLV,
  parameter logic [N_SLV*32-1:0] SLV_BASE = DEF_SLV_BASE,
  parameter logic [N_SLV*32-1:0] SLV_MASK = DEF_SLV_MASK
) (
  input  logic [31:0]                  addr,
  output logic                         hit,
  output logic [slot_width(N_SLV)-1:0] slot
);

  localparam int unsigned SLOT_W = slot_width(N_SLV);

  // Walk from the top so the lowest matching index is the one left standing.
  always_comb begin
    hit  = 1'b0;
    slot = '0;
    for (int i = int'(N_SLV) - 1; i >= 0; i--) begin
      if ((addr & SLV_MASK[i*32 +: 32]) == (SLV_BASE[i*32 +: 32] & SLV_MASK[i*32 +: 32])) begin
        hit  = 1'b1;
        slot = SLOT_W'(i);
      end
    end
  end

endmodule

// File: rtl/mmio_interconnect.sv
// Registered, handshaked CPU-to-peripheral interconnect with timeout and sticky error capture.
module mmio_interconnect
  import mmio_pkg::*;
#(
  parameter int unsigned         N_SLV    = DEF_N_SLV,
  parameter logic [N_SLV*32-1:0] SLV_BASE = DEF_SLV_BASE,
  parameter logic [N_SLV*32-1:0] SLV_MASK = DEF_SLV_MASK,
  parameter int unsigned         TIMEOUT  = DEF_TIMEOUT,
  parameter logic [31:0]         ERR_DATA = DEF_ERR_DATA
) (
  input  logic                 clk,
  input  logic                 reset,
  mmio_interconnect_if.slave   bus
);

  localparam int unsigned SLOT_W = slot_width(N_SLV);
  localparam int unsigned CNT_W  = $clog2(TIMEOUT);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [N_SLV-1:0]    sel_q, sel_d;
  logic                we_q, we_d;
  logic [31:0]         addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                bus_err_q, bus_err_d;
  logic [31:0]         err_addr_q, err_addr_d;

  logic                request;
  logic                dec_hit;
  logic [SLOT_W-1:0]   dec_slot;
  logic                ack_hit;
  logic                expire;
  logic                err_set;

  mmio_decode #(
    .N_SLV    (N_SLV),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK)
  ) u_decode (
    .addr (bus.cpu_addr),
    .hit  (dec_hit),
    .slot (dec_slot)
  );

  assign request = bus.cpu_we | bus.cpu_re;
  assign ack_hit = (state_q == WAIT) && ((bus.slv_ack & sel_q) != '0);
  assign expire  = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (request) state_d = dec_hit ? WAIT : DONE;
      WAIT:    if (ack_hit || expire) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Slave-side strobes exist only while in WAIT; everything else defaults to zero or hold.
  always_comb begin
    cnt_d   = '0;
    slot_d  = slot_q;
    sel_d   = '0;
    we_d    = 1'b0;
    addr_d  = '0;
    wdata_d = '0;
    rdata_d = rdata_q;
    err_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (request && dec_hit) begin
          slot_d  = dec_slot;
          sel_d   = N_SLV'(1) << dec_slot;
          we_d    = bus.cpu_we;
          addr_d  = bus.cpu_addr & ~SLV_MASK[{dec_slot, 5'd0} +: 32];
          wdata_d = bus.cpu_wdata;
        end else if (request) begin
          err_set = 1'b1;
          rdata_d = ERR_DATA;
        end
      end
      WAIT: begin
        if (ack_hit) begin
          if (!we_q) rdata_d = bus.slv_rdata[{slot_q, 5'd0} +: 32];
        end else if (expire) begin
          err_set = 1'b1;
          rdata_d = ERR_DATA;
        end else begin
          sel_d   = sel_q;
          we_d    = we_q;
          addr_d  = addr_q;
          wdata_d = wdata_q;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // A new error outranks a clear in the same cycle; only the first error address is kept.
  always_comb begin
    bus_err_d  = err_set | (bus_err_q & ~bus.err_clr);
    err_addr_d = bus.err_clr ? 32'd0 : err_addr_q;
    if (err_set && (!bus_err_q || bus.err_clr)) err_addr_d = bus.cpu_addr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      slot_q     <= '0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      bus_err_q  <= 1'b0;
      err_addr_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      slot_q     <= slot_d;
      sel_q      <= sel_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      bus_err_q  <= bus_err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign bus.cpu_stall = request & (state_q != DONE);
  assign bus.cpu_rdata = rdata_q;
  assign bus.bus_err   = bus_err_q;
  assign bus.err_addr  = err_addr_q;
  assign bus.slv_sel   = sel_q;
  assign bus.slv_we    = we_q;
  assign bus.slv_addr  = addr_q;
  assign bus.slv_wdata = wdata_q;

endmodule

// File: tb/tb_mmio_interconnect.sv
// Scoreboard bench: stimulus queues expected completions, a negedge monitor checks them.
module tb_mmio_interconnect;

  logic clk;
  logic reset;

  mmio_interconnect_if #(.N_SLV(4)) bus ();

  mmio_interconnect #(.N_SLV(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic [31:0] eaddr;
    int          stall;
    int          selc;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] saddr;
    logic [31:0] swdata;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errs   = 0;
  int   stall_c  = 0;
  int   sel_c    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] rdata, input logic err, input logic [31:0] eaddr,
                              input int stall, input int selc, input logic [3:0] sel, input logic we,
                              input logic [31:0] saddr, input logic [31:0] swdata);
    exp_t e;
    e.rdata = rdata; e.err = err; e.eaddr = eaddr; e.stall = stall; e.selc = selc;
    e.sel = sel; e.we = we; e.saddr = saddr; e.swdata = swdata;
    return e;
  endfunction

  // Monitor: slave strobes checked every selected cycle, full result checked on completion.
  always @(negedge clk) begin
    if (reset) begin
      stall_c = 0;
      sel_c   = 0;
    end else if ((bus.cpu_we | bus.cpu_re) && !bus.cpu_stall) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errs++;
        $display("FAIL unexpected_done: got completion expected none");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("cpu_rdata",  bus.cpu_rdata, e.rdata);
        chk("bus_err",    32'(bus.bus_err), 32'(e.err));
        chk("err_addr",   bus.err_addr, e.eaddr);
        chk("stall_cyc",  32'(stall_c), 32'(e.stall));
        chk("sel_cyc",    32'(sel_c), 32'(e.selc));
        chk("sel_done",   32'(bus.slv_sel), 32'd0);
      end
      stall_c = 0;
      sel_c   = 0;
    end else if (sb.size() != 0) begin
      if ((bus.cpu_we | bus.cpu_re) && bus.cpu_stall) stall_c++;
      if (bus.slv_sel != '0) begin
        sel_c++;
        chk("slv_sel",   32'(bus.slv_sel), 32'(sb[0].sel));
        chk("slv_we",    32'(bus.slv_we), 32'(sb[0].we));
        chk("slv_addr",  bus.slv_addr, sb[0].saddr);
        chk("slv_wdata", bus.slv_wdata, sb[0].swdata);
      end
    end else begin
      stall_c = 0;
      sel_c   = 0;
    end
  end

  // One CPU access; cycle k=0 is the IDLE request cycle. ad/bd select when the real/bogus acks fire.
  task automatic do_access(input logic [31:0] a, input logic [31:0] wd, input logic w, input logic r,
                           input int as, input int ad, input logic [31:0] ard,
                           input int bs, input int bd, input exp_t e);
    bit done;
    done = 1'b0;
    sb.push_back(e);
    @(posedge clk); #1;
    bus.cpu_addr = a; bus.cpu_wdata = wd; bus.cpu_we = w; bus.cpu_re = r;
    for (int k = 0; k < 64; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      bus.slv_ack = '0;
      if (k > 0 && !bus.cpu_stall) begin
        done = 1'b1;
        break;
      end
      if (k == ad) begin bus.slv_ack[as] = 1'b1; bus.slv_rdata[as*32 +: 32] = ard; end
      if (k == bd) begin bus.slv_ack[bs] = 1'b1; bus.slv_rdata[bs*32 +: 32] = 32'hBAD0_BAD0; end
    end
    if (!done) begin
      n_checks++;
      n_errs++;
      $display("FAIL access_timeout: got stall stuck expected completion at addr %h", a);
    end
  endtask

  task automatic clear_errors();
    @(posedge clk); #1;
    bus.cpu_we = 1'b0; bus.cpu_re = 1'b0; bus.err_clr = 1'b1;
    @(posedge clk); #1;
    bus.err_clr = 1'b0;
    chk("clr_bus_err",  32'(bus.bus_err), 32'd0);
    chk("clr_err_addr", bus.err_addr, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.cpu_we = 1'b0; bus.cpu_re = 1'b0;
    bus.err_clr = 1'b0; bus.slv_ack = '0; bus.slv_rdata = '0;
    #2;
    chk("rst_rdata",    bus.cpu_rdata, 32'd0);
    chk("rst_bus_err",  32'(bus.bus_err), 32'd0);
    chk("rst_err_addr", bus.err_addr, 32'd0);
    chk("rst_sel",      32'(bus.slv_sel), 32'd0);
    chk("rst_stall",    32'(bus.cpu_stall), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Read DMEM, ack in first WAIT cycle.
    do_access(32'h1001_0008, 32'h0, 1'b0, 1'b1, 0, 1, 32'h1234_5678, 0, -1,
              mk(32'h1234_5678, 1'b0, 32'h0, 2, 1, 4'b0001, 1'b0, 32'h8, 32'h0));
    // Write slot 1, ack on fifth WAIT cycle; read data stays.
    do_access(32'h1002_0000, 32'hA5, 1'b1, 1'b0, 1, 5, 32'hFFFF_FFFF, 0, -1,
              mk(32'h1234_5678, 1'b0, 32'h0, 6, 5, 4'b0010, 1'b1, 32'h0, 32'hA5));
    // Unmapped read.
    do_access(32'h2000_0000, 32'h0, 1'b0, 1'b1, 0, -1, 32'h0, 0, -1,
              mk(32'hDEAD_BEEF, 1'b1, 32'h2000_0000, 1, 0, 4'b0000, 1'b0, 32'h0, 32'h0));
    clear_errors();
    // Slot 2 never acks: timeout after 16 WAIT cycles.
    do_access(32'h1003_0010, 32'h0, 1'b0, 1'b1, 2, -1, 32'h0, 0, -1,
              mk(32'hDEAD_BEEF, 1'b1, 32'h1003_0010, 17, 16, 4'b0100, 1'b0, 32'h10, 32'h0));
    // Second error keeps the first address.
    do_access(32'h3000_0000, 32'h0, 1'b0, 1'b1, 0, -1, 32'h0, 0, -1,
              mk(32'hDEAD_BEEF, 1'b1, 32'h1003_0010, 1, 0, 4'b0000, 1'b0, 32'h0, 32'h0));
    clear_errors();
    // Ack lands in the same cycle the timeout would expire.
    do_access(32'h1004_0004, 32'h0, 1'b0, 1'b1, 3, 16, 32'hCAFE_F00D, 0, -1,
              mk(32'hCAFE_F00D, 1'b0, 32'h0, 17, 16, 4'b1000, 1'b0, 32'h4, 32'h0));
    // Slot 3 acks while slot 0 is selected; real ack on third WAIT cycle.
    do_access(32'h1001_0100, 32'h0, 1'b0, 1'b1, 0, 3, 32'h0BAD_F00D, 3, 1,
              mk(32'h0BAD_F00D, 1'b0, 32'h0, 4, 3, 4'b0001, 1'b0, 32'h100, 32'h0));
    // Target acks during the IDLE request cycle, which must not count.
    do_access(32'h1001_FFFC, 32'h0, 1'b0, 1'b1, 0, 2, 32'h55AA_55AA, 0, 0,
              mk(32'h55AA_55AA, 1'b0, 32'h0, 3, 2, 4'b0001, 1'b0, 32'hFFFC, 32'h0));
    // Read and write both set: treated as a write.
    do_access(32'h1002_0040, 32'h0000_7777, 1'b1, 1'b1, 1, 1, 32'h1111_1111, 0, -1,
              mk(32'h55AA_55AA, 1'b0, 32'h0, 2, 1, 4'b0010, 1'b1, 32'h40, 32'h0000_7777));
    do_access(32'h4000_0000, 32'h0, 1'b0, 1'b1, 0, -1, 32'h0, 0, -1,
              mk(32'hDEAD_BEEF, 1'b1, 32'h4000_0000, 1, 0, 4'b0000, 1'b0, 32'h0, 32'h0));

    // Reset in the middle of a WAIT.
    @(posedge clk); #1;
    bus.cpu_addr = 32'h1002_0020; bus.cpu_we = 1'b0; bus.cpu_re = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    chk("pre_rst_sel", 32'(bus.slv_sel), 32'b0010);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_sel",      32'(bus.slv_sel), 32'd0);
    chk("mid_rst_we",       32'(bus.slv_we), 32'd0);
    chk("mid_rst_addr",     bus.slv_addr, 32'd0);
    chk("mid_rst_rdata",    bus.cpu_rdata, 32'd0);
    chk("mid_rst_bus_err",  32'(bus.bus_err), 32'd0);
    chk("mid_rst_err_addr", bus.err_addr, 32'd0);
    chk("mid_rst_stall",    32'(bus.cpu_stall), 32'd1);
    bus.cpu_re = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;

    // Recovery after reset.
    do_access(32'h1001_0000, 32'h0, 1'b0, 1'b1, 0, 1, 32'h1111_2222, 0, -1,
              mk(32'h1111_2222, 1'b0, 32'h0, 2, 1, 4'b0001, 1'b0, 32'h0, 32'h0));
    @(posedge clk); #1;
    bus.cpu_we = 1'b0; bus.cpu_re = 1'b0;
    repeat (3) @(posedge clk);
    if (sb.size() != 0) begin
      n_checks++;
      n_errs++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
